// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_if
// Brief    : Decode-to-ALU issue bundle; master = environment, slave = stage.
// Revision : 1.0
// ============================================================================
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_control;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        is_branch;
    logic        illegal;
    logic        flush;
    logic        fwd_mem_en;
    logic        fwd_wb_en;
    logic [4:0]  fwd_mem_reg;
    logic [4:0]  fwd_wb_reg;
    logic [31:0] fwd_mem_data;
    logic [31:0] fwd_wb_data;

    modport master (
        output in_valid, in_instr, in_rs_data, in_rt_data, out_ready, flush,
               fwd_mem_en, fwd_wb_en, fwd_mem_reg, fwd_wb_reg, fwd_mem_data, fwd_wb_data,
        input  in_ready, out_valid, alu_control, srcA, srcB, rs_num, rt_num,
               dest_reg, reg_write, is_branch, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_rs_data, in_rt_data, out_ready, flush,
               fwd_mem_en, fwd_wb_en, fwd_mem_reg, fwd_wb_reg, fwd_mem_data, fwd_wb_data,
        output in_ready, out_valid, alu_control, srcA, srcB, rs_num, rt_num,
               dest_reg, reg_write, is_branch, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : MIPS-subset execute-issue stage: decode, operand build, one-entry
//            ALU pipeline register. Optional forwarding: ALU_ISSUE_FWD_EN.
// Revision : 1.0
// ============================================================================
module alu_issue (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_issue_if.slave bus
);
    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]  r_state;
    logic [2:0]  r_alu_control;
    logic [31:0] r_rs_val;
    logic [31:0] r_rt_val;
    logic [31:0] r_imm;
    logic        r_use_imm;
    logic [4:0]  r_rs_num;
    logic [4:0]  r_rt_num;
    logic [4:0]  r_dest;
    logic        r_reg_write;
    logic        r_is_branch;
    logic        r_illegal;

    logic        w_in_ready;
    logic        w_load;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs_field;
    logic [4:0]  w_rt_field;
    logic [2:0]  w_ctl;
    logic        w_use_imm;
    logic [31:0] w_imm;
    logic [4:0]  w_dest;
    logic        w_rw;
    logic        w_br;
    logic        w_ill;
    logic [31:0] w_in_rs;
    logic [31:0] w_in_rt;
    logic [31:0] w_held_rs;
    logic [31:0] w_held_rt;

    assign w_op       = bus.in_instr[31:26];
    assign w_funct    = bus.in_instr[5:0];
    assign w_rs_field = bus.in_instr[25:21];
    assign w_rt_field = bus.in_instr[20:16];

    assign w_in_ready = (r_state == c_ST_EMPTY) || bus.out_ready;
    assign w_load     = bus.in_valid && w_in_ready && !bus.flush;

    always_comb begin
        w_ctl     = 3'b010;
        w_use_imm = 1'b0;
        w_imm     = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
        w_dest    = w_rt_field;
        w_rw      = 1'b0;
        w_br      = 1'b0;
        w_ill     = 1'b0;
        case (w_op)
            6'h00: begin
                w_dest = bus.in_instr[15:11];
                w_rw   = 1'b1;
                case (w_funct)
                    6'h20, 6'h21: w_ctl = 3'b010;
                    6'h22, 6'h23: w_ctl = 3'b110;
                    6'h24:        w_ctl = 3'b000;
                    6'h25:        w_ctl = 3'b001;
                    6'h27:        w_ctl = 3'b101;
                    6'h2A:        w_ctl = 3'b111;
                    default: begin
                        w_ill = 1'b1;
                        w_rw  = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09: begin w_use_imm = 1'b1; w_rw = 1'b1; end
            6'h0A: begin w_ctl = 3'b111; w_use_imm = 1'b1; w_rw = 1'b1; end
            6'h0C: begin
                w_ctl = 3'b000; w_use_imm = 1'b1; w_rw = 1'b1;
                w_imm = {16'h0000, bus.in_instr[15:0]};
            end
            6'h0D: begin
                w_ctl = 3'b001; w_use_imm = 1'b1; w_rw = 1'b1;
                w_imm = {16'h0000, bus.in_instr[15:0]};
            end
            6'h23: begin w_use_imm = 1'b1; w_rw = 1'b1; end
            6'h2B: w_use_imm = 1'b1;
            6'h04: begin w_ctl = 3'b110; w_br = 1'b1; end
            default: w_ill = 1'b1;
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    // mem stage is younger than wb, so its result wins; $0 is hardwired zero
    function automatic logic [31:0] f_fwd(input logic [4:0] num, input logic [31:0] val);
        if (num != 5'd0 && bus.fwd_mem_en && bus.fwd_mem_reg == num)
            f_fwd = bus.fwd_mem_data;
        else if (num != 5'd0 && bus.fwd_wb_en && bus.fwd_wb_reg == num)
            f_fwd = bus.fwd_wb_data;
        else
            f_fwd = val;
    endfunction

    assign w_in_rs   = f_fwd(w_rs_field, bus.in_rs_data);
    assign w_in_rt   = f_fwd(w_rt_field, bus.in_rt_data);
    assign w_held_rs = f_fwd(r_rs_num, r_rs_val);
    assign w_held_rt = f_fwd(r_rt_num, r_rt_val);

    logic w_unused_shamt;
    assign w_unused_shamt = ^bus.in_instr[10:6];
`else
    assign w_in_rs   = bus.in_rs_data;
    assign w_in_rt   = bus.in_rt_data;
    assign w_held_rs = r_rs_val;
    assign w_held_rt = r_rt_val;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{bus.in_instr[10:6], bus.fwd_mem_en, bus.fwd_wb_en,
                            bus.fwd_mem_reg, bus.fwd_wb_reg, bus.fwd_mem_data,
                            bus.fwd_wb_data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_EMPTY;
            r_alu_control <= 3'b000;
            r_rs_val      <= 32'h0;
            r_rt_val      <= 32'h0;
            r_imm         <= 32'h0;
            r_use_imm     <= 1'b0;
            r_rs_num      <= 5'd0;
            r_rt_num      <= 5'd0;
            r_dest        <= 5'd0;
            r_reg_write   <= 1'b0;
            r_is_branch   <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            if (bus.flush)
                r_state <= c_ST_EMPTY;
            else if (w_load)
                r_state <= c_ST_FULL;
            else if (bus.out_ready)
                r_state <= c_ST_EMPTY;

            if (w_load) begin
                r_alu_control <= w_ctl;
                r_rs_val      <= w_in_rs;
                r_rt_val      <= w_in_rt;
                r_imm         <= w_imm;
                r_use_imm     <= w_use_imm;
                r_rs_num      <= w_rs_field;
                r_rt_num      <= w_rt_field;
                r_dest        <= w_dest;
                r_reg_write   <= w_rw;
                r_is_branch   <= w_br;
                r_illegal     <= w_ill;
            end else if (r_state == c_ST_FULL) begin
                // capture forwarded values so a stalled entry survives the producer retiring
                r_rs_val <= w_held_rs;
                r_rt_val <= w_held_rt;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == c_ST_FULL);
    assign bus.alu_control = r_alu_control;
    assign bus.srcA        = w_held_rs;
    assign bus.srcB        = r_use_imm ? r_imm : w_held_rt;
    assign bus.rs_num      = r_rs_num;
    assign bus.rt_num      = r_rt_num;
    assign bus.dest_reg    = r_dest;
    assign bus.reg_write   = r_reg_write;
    assign bus.is_branch   = r_is_branch;
    assign bus.illegal     = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Self-checking bench for alu_issue: decode vector table, flow
//            sequences, forwarding sequences and a randomized reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_issue_if bus ();
    alu_issue dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [2:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        rw;
        logic        br;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic        ill;
        logic [2:0]  ctl;
        logic        useimm;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic        rw;
        logic        br;
    } dec_t;

    // reference model state: what the held entry should contain
    logic        m_valid = 1'b0;
    dec_t        m_d;
    logic [4:0]  m_rsn, m_rtn;
    logic [31:0] m_rsv, m_rtv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input logic [5:0] f);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t        d;
        logic [5:0]  op    = ins[31:26];
        logic [5:0]  fn    = ins[5:0];
        logic [31:0] sext  = 32'($signed(ins[15:0]));
        logic [31:0] zext  = 32'(ins[15:0]);
        d = '{ill: 1'b0, ctl: 3'b010, useimm: 1'b0, imm: 32'h0, dest: ins[20:16], rw: 1'b0, br: 1'b0};
        if (op == 6'h00) begin
            d.dest = ins[15:11];
            d.rw   = 1'b1;
            if (fn == 6'h20 || fn == 6'h21)      d.ctl = 3'b010;
            else if (fn == 6'h22 || fn == 6'h23) d.ctl = 3'b110;
            else if (fn == 6'h24)                d.ctl = 3'b000;
            else if (fn == 6'h25)                d.ctl = 3'b001;
            else if (fn == 6'h27)                d.ctl = 3'b101;
            else if (fn == 6'h2A)                d.ctl = 3'b111;
            else begin d.ill = 1'b1; d.rw = 1'b0; end
        end else if (op == 6'h08 || op == 6'h09 || op == 6'h23) begin
            d.useimm = 1'b1; d.imm = sext; d.rw = 1'b1;
        end else if (op == 6'h2B) begin
            d.useimm = 1'b1; d.imm = sext;
        end else if (op == 6'h0A) begin
            d.ctl = 3'b111; d.useimm = 1'b1; d.imm = sext; d.rw = 1'b1;
        end else if (op == 6'h0C) begin
            d.ctl = 3'b000; d.useimm = 1'b1; d.imm = zext; d.rw = 1'b1;
        end else if (op == 6'h0D) begin
            d.ctl = 3'b001; d.useimm = 1'b1; d.imm = zext; d.rw = 1'b1;
        end else if (op == 6'h04) begin
            d.ctl = 3'b110; d.br = 1'b1;
        end else begin
            d.ill = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] n, input logic [31:0] v);
`ifdef ALU_ISSUE_FWD_EN
        if (n != 5'd0 && bus.fwd_mem_en && bus.fwd_mem_reg == n) return bus.fwd_mem_data;
        if (n != 5'd0 && bus.fwd_wb_en && bus.fwd_wb_reg == n) return bus.fwd_wb_data;
`endif
        return v;
    endfunction

    task automatic model_step();
        logic rdy = !m_valid || bus.out_ready;
        if (rst) begin
            m_valid = 1'b0;
            m_d     = '0;
            m_rsn = 5'd0; m_rtn = 5'd0; m_rsv = 32'h0; m_rtv = 32'h0;
        end else if (bus.flush) begin
            m_valid = 1'b0;
        end else if (bus.in_valid && rdy) begin
            m_valid = 1'b1;
            m_d     = ref_decode(bus.in_instr);
            m_rsn   = bus.in_instr[25:21];
            m_rtn   = bus.in_instr[20:16];
            m_rsv   = ref_fwd(m_rsn, bus.in_rs_data);
            m_rtv   = ref_fwd(m_rtn, bus.in_rt_data);
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end else if (m_valid) begin
            m_rsv = ref_fwd(m_rsn, m_rsv);
            m_rtv = ref_fwd(m_rtn, m_rtv);
        end
    endtask

    // inputs must already be driven; returns #1 after the next rising edge
    task automatic cycle();
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("m_ctl",    32'(bus.alu_control), 32'(m_d.ctl));
            chk("m_srcA",   bus.srcA, ref_fwd(m_rsn, m_rsv));
            chk("m_srcB",   bus.srcB, m_d.useimm ? m_d.imm : ref_fwd(m_rtn, m_rtv));
            chk("m_rs_num", 32'(bus.rs_num), 32'(m_rsn));
            chk("m_rt_num", 32'(bus.rt_num), 32'(m_rtn));
            chk("m_dest",   32'(bus.dest_reg), 32'(m_d.dest));
            chk("m_rw",     32'(bus.reg_write), 32'(m_d.rw));
            chk("m_br",     32'(bus.is_branch), 32'(m_d.br));
            chk("m_ill",    32'(bus.illegal), 32'(m_d.ill));
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_rs_data = 32'h0; bus.in_rt_data = 32'h0;
        bus.out_ready = 1'b1; bus.flush = 1'b0;
        bus.fwd_mem_en = 1'b0; bus.fwd_wb_en = 1'b0; bus.fwd_mem_reg = 5'd0; bus.fwd_wb_reg = 5'd0;
        bus.fwd_mem_data = 32'h0; bus.fwd_wb_data = 32'h0;
    endtask

    task automatic load(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd);
        bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_rs_data = rsd; bus.in_rt_data = rtd;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    vec_t vt[$];

    initial begin
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready",  32'(bus.in_ready), 32'h1);
        chk("rst_ctl",       32'(bus.alu_control), 32'h0);
        chk("rst_srcA",      bus.srcA, 32'h0);
        chk("rst_srcB",      bus.srcB, 32'h0);
        chk("rst_nums",      32'({bus.rs_num, bus.rt_num, bus.dest_reg}), 32'h0);
        chk("rst_flags",     32'({bus.reg_write, bus.is_branch, bus.illegal}), 32'h0);

        // ---------------- decode vector table ----------------
        vt.push_back('{mk_r(1,2,3,6'h20), 32'd5, 32'd7, 3'b010, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_r(4,5,6,6'h22), 32'd10, 32'd3, 3'b110, 32'd10, 32'd3, 5'd6, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_r(1,2,7,6'h24), 32'hF0F0, 32'hFF00, 3'b000, 32'hF0F0, 32'hFF00, 5'd7, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_r(1,2,8,6'h25), 32'h1, 32'h2, 3'b001, 32'h1, 32'h2, 5'd8, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_r(1,2,9,6'h27), 32'h3, 32'h4, 3'b101, 32'h3, 32'h4, 5'd9, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_r(1,2,10,6'h2A), 32'h5, 32'h6, 3'b111, 32'h5, 32'h6, 5'd10, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_r(1,2,11,6'h21), 32'h7, 32'h8, 3'b010, 32'h7, 32'h8, 5'd11, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_r(1,2,12,6'h23), 32'h9, 32'hA, 3'b110, 32'h9, 32'hA, 5'd12, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_i(6'h0C,1,4,16'hFFFF), 32'hFFFF0000, 32'h123, 3'b000, 32'hFFFF0000, 32'h0000FFFF, 5'd4, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_i(6'h0A,1,5,16'h8000), 32'd3, 32'h0, 3'b111, 32'd3, 32'hFFFF8000, 5'd5, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_i(6'h08,2,6,16'hFFFE), 32'd20, 32'h0, 3'b010, 32'd20, 32'hFFFFFFFE, 5'd6, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_i(6'h09,2,6,16'h7FFF), 32'd21, 32'h0, 3'b010, 32'd21, 32'h00007FFF, 5'd6, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_i(6'h0D,2,7,16'h8001), 32'd22, 32'h0, 3'b001, 32'd22, 32'h00008001, 5'd7, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_i(6'h23,2,9,16'h0010), 32'h1000, 32'h0, 3'b010, 32'h1000, 32'h10, 5'd9, 1'b1, 1'b0, 1'b0});
        vt.push_back('{mk_i(6'h2B,2,9,16'hFFFC), 32'h1000, 32'h55, 3'b010, 32'h1000, 32'hFFFFFFFC, 5'd9, 1'b0, 1'b0, 1'b0});
        vt.push_back('{mk_i(6'h04,1,2,16'h0005), 32'h1234, 32'h4321, 3'b110, 32'h1234, 32'h4321, 5'd2, 1'b0, 1'b1, 1'b0});
        vt.push_back('{mk_i(6'h3F,1,2,16'h0000), 32'h11, 32'h22, 3'b010, 32'h11, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1});
        vt.push_back('{mk_r(1,2,3,6'h00), 32'h11, 32'h22, 3'b010, 32'h11, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1});

        bus.out_ready = 1'b1;
        foreach (vt[i]) begin
            bus.in_valid = 1'b1; bus.in_instr = vt[i].instr;
            bus.in_rs_data = vt[i].rs; bus.in_rt_data = vt[i].rt;
            cycle();
            chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("v%0d_ctl", i),   32'(bus.alu_control), 32'(vt[i].ctl));
            chk($sformatf("v%0d_rw", i),    32'(bus.reg_write), 32'(vt[i].rw));
            chk($sformatf("v%0d_br", i),    32'(bus.is_branch), 32'(vt[i].br));
            chk($sformatf("v%0d_ill", i),   32'(bus.illegal), 32'(vt[i].ill));
            chk($sformatf("v%0d_rsn", i),   32'(bus.rs_num), 32'(vt[i].instr[25:21]));
            if (!vt[i].ill) begin
                chk($sformatf("v%0d_srcA", i), bus.srcA, vt[i].a);
                chk($sformatf("v%0d_srcB", i), bus.srcB, vt[i].b);
                chk($sformatf("v%0d_dest", i), 32'(bus.dest_reg), 32'(vt[i].dest));
            end
        end
        bus.in_valid = 1'b0;
        cycle();
        chk("drain_empty", 32'(bus.out_valid), 32'h0);

        // ---------------- back-to-back stream ----------------
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.in_instr = mk_r(1, 2, i + 1, 6'h20);
            bus.in_rs_data = 32'(i); bus.in_rt_data = 32'(i * 3);
            cycle();
            chk($sformatf("b2b%0d_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("b2b%0d_dest", i),  32'(bus.dest_reg), 32'(i + 1));
            chk($sformatf("b2b%0d_srcA", i),  bus.srcA, 32'(i));
        end

        // ---------------- stall for 3 cycles ----------------
        load(mk_r(1, 2, 20, 6'h25), 32'hA, 32'hB);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = mk_r(1, 2, 21, 6'h20);
        bus.in_rs_data = 32'hC; bus.in_rt_data = 32'hD;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("stall%0d_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("stall%0d_ready", i), 32'(bus.in_ready), 32'h0);
            chk($sformatf("stall%0d_dest", i),  32'(bus.dest_reg), 32'd20);
            chk($sformatf("stall%0d_ctl", i),   32'(bus.alu_control), 32'b001);
        end
        bus.out_ready = 1'b1;
        cycle();
        chk("release_dest", 32'(bus.dest_reg), 32'd21);
        chk("release_srcA", bus.srcA, 32'hC);

        // ---------------- flush while full ----------------
        bus.flush = 1'b1; bus.in_instr = mk_r(1, 2, 22, 6'h20);
        cycle();
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        cycle();
        chk("flush_dropped", 32'(bus.out_valid), 32'h0);

`ifdef ALU_ISSUE_FWD_EN
        // ---------------- forwarding ----------------
        load(mk_r(2, 3, 4, 6'h20), 32'h1, 32'h0);
        bus.out_ready = 1'b0;
        bus.fwd_mem_en = 1'b1; bus.fwd_mem_reg = 5'd2; bus.fwd_mem_data = 32'h55;
        #1 chk("fwd_mem", bus.srcA, 32'h55);
        bus.fwd_wb_en = 1'b1; bus.fwd_wb_reg = 5'd2; bus.fwd_wb_data = 32'h66;
        #1 chk("fwd_mem_prio", bus.srcA, 32'h55);
        bus.out_ready = 1'b1;
        load(mk_r(0, 3, 4, 6'h20), 32'h1, 32'h0);
        bus.fwd_mem_reg = 5'd0; bus.fwd_mem_data = 32'h77;
        bus.fwd_wb_reg = 5'd0; bus.fwd_wb_data = 32'h88;
        #1 chk("fwd_reg0", bus.srcA, 32'h1);
        bus.fwd_mem_en = 1'b0; bus.fwd_wb_en = 1'b0;
        load(mk_r(2, 3, 4, 6'h20), 32'h1, 32'h0);
        bus.out_ready = 1'b0;
        bus.fwd_wb_en = 1'b1; bus.fwd_wb_reg = 5'd2; bus.fwd_wb_data = 32'h9;
        cycle();
        bus.fwd_wb_en = 1'b0;
        #1 chk("fwd_stall_keep", bus.srcA, 32'h9);
        cycle();
        chk("fwd_stall_keep2", bus.srcA, 32'h9);
        bus.out_ready = 1'b1;
        cycle();
`endif

        // ---------------- randomized run against the model ----------------
        for (int n = 0; n < 400; n++) begin
            logic [5:0] rf[9];
            logic [5:0] io[9];
            rf = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
            io = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3F};
            rst = ($urandom_range(0, 49) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 1) == 0)
                bus.in_instr = {6'h00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                5'($urandom_range(0, 31)), 5'($urandom), rf[$urandom_range(0, 8)]};
            else
                bus.in_instr = {io[$urandom_range(0, 8)], 5'($urandom_range(0, 3)),
                                5'($urandom_range(0, 3)), 16'($urandom)};
            bus.in_rs_data = $urandom; bus.in_rt_data = $urandom;
            bus.fwd_mem_en = $urandom_range(0, 1) == 1; bus.fwd_mem_reg = 5'($urandom_range(0, 3));
            bus.fwd_wb_en  = $urandom_range(0, 1) == 1; bus.fwd_wb_reg  = 5'($urandom_range(0, 3));
            bus.fwd_mem_data = $urandom; bus.fwd_wb_data = $urandom;
            cycle();
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
